// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Requester IDs double as the 1-bit entries of the outstanding-ID FIFO.
package mem_port_arbiter_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  // Attributes driven on behalf of the fetch side, which only ever reads full words.
  localparam logic        NOP_WE    = 1'b0;
  localparam logic [3:0]  NOP_BE    = 4'hF;
  localparam logic [31:0] NOP_WDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO recording which requester owns each outstanding memory transaction.
// Push is ignored when full and pop is ignored when empty.
module mem_arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic                         wdata,
  input  logic                         pop,
  output logic                         rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage carries no reset; an entry is only ever read after it was written,
  // and the reset-cleared count is what defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and load/store,
// routing in-order responses back to the side that issued each transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  req_id_e    sel;
  req_id_e    lock_id;
  req_id_e    rr_last;
  logic       locked;
  logic       sel_req;
  logic       xfer;
  logic       rsp_ok;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // NOTE: every combinational output gets a default before any branch so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    sel = REQ_INSTR;
    if (locked) begin
      sel = lock_id;
    end else if (instr_req_i && data_req_i) begin
      if (ARB_MODE == 0) sel = REQ_DATA;
      else               sel = (rr_last == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    end else if (data_req_i) begin
      sel = REQ_DATA;
    end
  end

  assign sel_req   = (sel == REQ_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = sel_req & ~fifo_full & ~rst_i;
  assign xfer      = mem_req_o & mem_gnt_i;

  assign mem_we_o    = (sel == REQ_DATA) ? data_we_i    : NOP_WE;
  assign mem_be_o    = (sel == REQ_DATA) ? data_be_i    : NOP_BE;
  assign mem_addr_o  = (sel == REQ_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (sel == REQ_DATA) ? data_wdata_i : NOP_WDATA;

  assign instr_gnt_o = xfer & (sel == REQ_INSTR);
  assign data_gnt_o  = xfer & (sel == REQ_DATA);

  // The lock pins the selection while a request waits, so its attributes never change mid-handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked  <= 1'b0;
      lock_id <= REQ_INSTR;
      rr_last <= REQ_INSTR;
    end else if (xfer) begin
      locked  <= 1'b0;
      rr_last <= sel;
    end else if (mem_req_o) begin
      locked  <= 1'b1;
      lock_id <= sel;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (xfer),
    .wdata (sel),
    .pop   (rsp_ok),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A response with nothing outstanding (e.g. a stale one after reset) is dropped.
  assign rsp_ok = mem_rvalid_i & ~fifo_empty & ~rst_i;

  assign instr_rvalid_o = rsp_ok & (fifo_head == REQ_INSTR);
  assign data_rvalid_o  = rsp_ok & (fifo_head == REQ_DATA);
  assign instr_err_o    = mem_err_i & instr_rvalid_o;
  assign data_err_o     = mem_err_i & data_rvalid_o;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_OUT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .ARB_MODE(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owners of outstanding transactions (1 = data), who won last,
  // and which side a not-yet-granted request belongs to.
  bit owners[$];
  bit last_was_data;
  bit waiting;
  bit waiting_side;
  bit m_igrant, m_dgrant;

  // Observed DUT outputs of the most recent step, for directed checks.
  logic        obs_igrant, obs_dgrant, obs_mreq, obs_we, obs_irv, obs_drv, obs_ierr, obs_derr;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;

  function automatic bit pick_data_side();
    if (waiting) return waiting_side;
    if (instr_req_i && data_req_i) return !last_was_data;
    return data_req_i;
  endfunction

  // Inputs are already driven (posedge+1); sample at the falling edge, then advance.
  task automatic step();
    bit side, want, e_req, e_xfer, e_resp, head;
    #4;
    obs_igrant = instr_gnt_o;    obs_dgrant = data_gnt_o;   obs_mreq = mem_req_o;
    obs_addr   = mem_addr_o;     obs_we     = mem_we_o;     obs_be   = mem_be_o;
    obs_wdata  = mem_wdata_o;    obs_irv    = instr_rvalid_o; obs_drv = data_rvalid_o;
    obs_ierr   = instr_err_o;    obs_derr   = data_err_o;
    m_igrant = 1'b0;
    m_dgrant = 1'b0;
    if (rst_i) begin
      check("rst_mem_req", mem_req_o, 0);
      check("rst_instr_gnt", instr_gnt_o, 0);
      check("rst_data_gnt", data_gnt_o, 0);
      check("rst_instr_rvalid", instr_rvalid_o, 0);
      check("rst_data_rvalid", data_rvalid_o, 0);
      check("rst_instr_err", instr_err_o, 0);
      check("rst_data_err", data_err_o, 0);
      owners.delete();
      last_was_data = 1'b0;
      waiting       = 1'b0;
    end else begin
      side   = pick_data_side();
      want   = side ? data_req_i : instr_req_i;
      e_req  = want && (owners.size() < MAX_OUT);
      e_xfer = e_req && mem_gnt_i;
      e_resp = mem_rvalid_i && (owners.size() > 0);
      head   = e_resp ? owners[0] : 1'b0;
      check("mem_req", mem_req_o, e_req);
      check("instr_gnt", instr_gnt_o, e_xfer && !side);
      check("data_gnt", data_gnt_o, e_xfer && side);
      check("instr_rvalid", instr_rvalid_o, e_resp && !head);
      check("data_rvalid", data_rvalid_o, e_resp && head);
      check("instr_err", instr_err_o, e_resp && !head && mem_err_i);
      check("data_err", data_err_o, e_resp && head && mem_err_i);
      if (e_req) begin
        check("mem_addr", mem_addr_o, side ? data_addr_i : instr_addr_i);
        check("mem_we", mem_we_o, side ? data_we_i : 1'b0);
        check("mem_be", mem_be_o, side ? data_be_i : 4'hF);
        check("mem_wdata", mem_wdata_o, side ? data_wdata_i : 32'h0);
      end
      if (e_resp) begin
        if (head) check("data_rdata", data_rdata_o, mem_rdata_i);
        else      check("instr_rdata", instr_rdata_o, mem_rdata_i);
        void'(owners.pop_front());
      end
      if (e_xfer) begin
        owners.push_back(side);
        last_was_data = side;
        waiting       = 1'b0;
        m_igrant      = !side;
        m_dgrant      = side;
      end else if (e_req) begin
        waiting      = 1'b1;
        waiting_side = side;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
  endtask

  task automatic drain();
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_err_i = 0;
    repeat (MAX_OUT + 1) begin
      mem_rvalid_i = (owners.size() > 0);
      mem_rdata_i  = $urandom;
      step();
    end
    mem_rvalid_i = 0;
  endtask

  initial begin
    rst_i = 1;
    instr_req_i = 1; instr_addr_i = 32'h0000_0100;
    data_req_i = 1; data_we_i = 0; data_be_i = 4'hF;
    data_addr_i = 32'h0000_2000; data_wdata_i = 32'h0;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678; mem_err_i = 1;
    @(posedge clk_i); #1;
    repeat (2) step();

    // Round-robin from reset: data, instr, data; responses follow one cycle later.
    rst_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
    step();
    check("alt1_data_gnt", obs_dgrant, 1);
    mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5_0001;
    step();
    check("alt2_instr_gnt", obs_igrant, 1);
    check("alt2_data_rvalid", obs_drv, 1);
    mem_rdata_i = 32'hA5A5_0002;
    step();
    check("alt3_data_gnt", obs_dgrant, 1);
    check("alt3_instr_rvalid", obs_irv, 1);
    drain();

    // Waiting data request holds the port even after instr rises.
    set_idle();
    data_req_i = 1; data_addr_i = 32'h0000_3000;
    instr_addr_i = 32'h0000_0400;
    step();
    instr_req_i = 1;
    step();
    check("lock_addr_c2", obs_addr, 32'h0000_3000);
    step();
    check("lock_addr_c3", obs_addr, 32'h0000_3000);
    mem_gnt_i = 1;
    step();
    check("lock_data_gnt_c4", obs_dgrant, 1);
    data_req_i = 0;
    step();
    check("lock_instr_gnt_c5", obs_igrant, 1);
    drain();

    // FIFO full blocks, even in the cycle a response pops an entry.
    set_idle();
    instr_req_i = 1; mem_gnt_i = 1;
    repeat (2) step();
    step();
    check("full_block", obs_mreq, 0);
    mem_rvalid_i = 1;
    step();
    check("full_block_on_pop", obs_mreq, 0);
    mem_rvalid_i = 0;
    step();
    check("full_reissue", obs_mreq, 1);
    drain();

    // Store attributes pass straight through; error routed to data side only.
    set_idle();
    data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011;
    data_addr_i = 32'h0000_1004; data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1;
    step();
    check("store_addr", obs_addr, 32'h0000_1004);
    check("store_we", obs_we, 1);
    check("store_be", obs_be, 4'b0011);
    check("store_wdata", obs_wdata, 32'hDEAD_BEEF);
    set_idle();
    mem_rvalid_i = 1; mem_err_i = 1;
    step();
    check("store_data_err", obs_derr, 1);
    check("store_instr_err", obs_ierr, 0);

    // Stray response on an empty FIFO is ignored and leaves the count at zero.
    set_idle();
    mem_rvalid_i = 1;
    step();
    check("stray_instr_rvalid", obs_irv, 0);
    check("stray_data_rvalid", obs_drv, 0);
    mem_rvalid_i = 0; instr_req_i = 1; mem_gnt_i = 1;
    step(); check("stray_cnt_g1", obs_igrant, 1);
    step(); check("stray_cnt_g2", obs_igrant, 1);
    step(); check("stray_cnt_g3", obs_igrant, 0);

    // Reset with two outstanding discards them; a late response is ignored.
    rst_i = 1;
    step();
    rst_i = 0; set_idle(); mem_rvalid_i = 1;
    step();
    check("stale_instr_rvalid", obs_irv, 0);
    check("stale_data_rvalid", obs_drv, 0);
    mem_rvalid_i = 0; instr_req_i = 1; mem_gnt_i = 1;
    step(); check("post_rst_g1", obs_igrant, 1);
    step(); check("post_rst_g2", obs_igrant, 1);
    drain();

    // Randomized traffic: requesters hold until granted, memory answers in order.
    set_idle();
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if (!instr_req_i || m_igrant) begin
        instr_req_i  = $urandom_range(0, 1);
        instr_addr_i = $urandom;
      end
      if (!data_req_i || m_dgrant) begin
        data_req_i   = $urandom_range(0, 1);
        data_we_i    = $urandom_range(0, 1);
        data_be_i    = 4'($urandom);
        data_addr_i  = $urandom;
        data_wdata_i = $urandom;
      end
      mem_gnt_i = ($urandom_range(0, 9) < 6);
      if (owners.size() > 0) mem_rvalid_i = ($urandom_range(0, 2) != 0);
      else                   mem_rvalid_i = ($urandom_range(0, 9) == 0);
      mem_rdata_i = $urandom;
      mem_err_i   = ($urandom_range(0, 7) == 0);
      step();
    end
    rst_i = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch side and the load/store side. Both sides, and the memory, use the req/gnt/rvalid handshake of the instruction memory interface.
- Arbitrates new requests between the two sides.
- Holds the selection stable while a request is waiting for its grant.
- Records which requester owns each outstanding transaction in an in-order ID FIFO.
- Routes each rvalid/rdata/err response back to the requester that issued it.

Parameters:
MAX_OUTSTANDING  2  maximum granted-but-unanswered transactions (1..8)
ARB_MODE  1  0 = fixed priority (data over instr); 1 = round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch address
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error
data_req_i  in  1  load/store request
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_addr_i  in  32  load/store address
data_wdata_i  in  32  store data
data_gnt_o  out  1  load/store accepted
data_rvalid_o  out  1  load/store response valid
data_rdata_o  out  32  load read data
data_err_o  out  1  load/store bus error
mem_req_o  out  1  request to memory
mem_we_o  out  1  write enable to memory
mem_be_o  out  4  byte enables to memory
mem_addr_o  out  32  address to memory
mem_wdata_o  out  32  write data to memory
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  32  memory read data
mem_err_i  in  1  memory bus error

Behaviour:
- Handshake: a requester holds req and its attributes stable until gnt. A transfer occurs on any cycle with mem_req_o & mem_gnt_i. Responses return in issue order, no earlier than the cycle after the grant.
- Selection (combinational):
  - If locked, use the locked requester.
  - Else, if only one req is high, select it.
  - If both are high:
    - ARB_MODE=0 selects data.
    - ARB_MODE=1 selects the side not granted last; rr_last resets to instr, so data wins first.
- mem_req_o = selected req & ~fifo_full.
- mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o are muxed from the selected side. Instr side drives we=0, be=4'hF, wdata=0.
- Lock register (prevents switching while a request waits for its grant):
  - Sets when mem_req_o=1 and mem_gnt_i=0; records the selected requester.
  - Clears on the grant.
- Grants:
  - instr_gnt_o = mem_gnt_i & mem_req_o & sel==instr.
  - data_gnt_o likewise for sel==data.
  - The unselected side sees gnt=0.
- ID FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries, count width $clog2(MAX_OUTSTANDING+1).
  - Push the selected ID on transfer; pop on mem_rvalid_i.
  - Simultaneous push and pop: count unchanged, pointers both advance.
  - Full blocks new requests even when a pop occurs in the same cycle; the request is issued the next cycle.
- Response routing:
  - instr_rvalid_o = mem_rvalid_i & ~fifo_empty & head==instr; data_rvalid_o likewise.
  - *_err_o = mem_err_i gated by the same term.
  - *_rdata_o = mem_rdata_i, passed through unconditionally; valid only with rvalid.
- mem_rvalid_i while the FIFO is empty: ignored (no rvalid_o, no pop).
- Latency: grant is combinational from mem_gnt_i; response is combinational from mem_rvalid_i. No added cycles.
- Reset:
  - FIFO empty, lock clear, rr_last=instr.
  - Every rvalid_o/err_o/gnt_o = 0 while rst_i=1; mem_req_o=0 while rst_i=1.
  - Reset mid-transaction discards all outstanding IDs; late memory responses after reset are ignored.

Decomposition:
- Shared package: requester ID constants REQ_INSTR=1'b0, REQ_DATA=1'b1, and NOP/default constants (be 4'hF).
- One sub-module: mem_arb_id_fifo (synchronous FIFO, parameterised depth, full/empty/count).

Test Plan:
- Both req high from reset, ARB_MODE=1, mem_gnt_i=1 every cycle -> grants alternate data, instr, data. FIFO IDs pop in the same order, and rvalid is routed to matching sides one cycle later.
- data_req only, mem_gnt_i=0 for 3 cycles, instr_req rises in cycle 2 -> mem_addr_o stays the data address. Data is granted in cycle 4, instr in cycle 5.
- MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 with req pending. One rvalid -> mem_req_o=1 the following cycle.
- Store: data_we_i=1, be=4'b0011, addr 32'h0000_1004, wdata 32'hDEAD_BEEF -> mem_* carries exactly these values. Response mem_err_i=1 -> data_err_o=1, instr_err_o=0.
- mem_rvalid_i pulse with the FIFO empty -> no rvalid_o asserted and count stays 0.
- rst_i asserted with 2 outstanding -> next cycle count=0, all gnt/rvalid outputs 0. A stale mem_rvalid_i is ignored.
